// File: rtl/id_exe_stage_reg_if.sv
// ID/EXE stage-register bundle: the decoded ID instruction on the way in, the EXE view on the way out.
// master: ID side, drives the *_in fields plus flush/freeze and observes the registered outputs.
// slave:  the stage register, samples the *_in fields and drives the registered outputs.
interface id_exe_stage_reg_if #(
    parameter int REG_LEN      = 32,
    parameter int SHIFT_OP_LEN = 12,
    parameter int IMM24_LEN    = 24,
    parameter int CMD_LEN      = 4
);
    // stage control
    logic                    flush;
    logic                    freeze;

    // ID-side fields
    logic [REG_LEN-1:0]      pc_in;
    logic                    wb_en_in;
    logic                    mem_r_en_in;
    logic                    mem_w_en_in;
    logic                    b_in;
    logic                    s_in;
    logic                    imm_in;
    logic [CMD_LEN-1:0]      exe_cmd_in;
    logic [REG_LEN-1:0]      val_rn_in;
    logic [REG_LEN-1:0]      val_rm_in;
    logic [SHIFT_OP_LEN-1:0] shift_operand_in;
    logic [IMM24_LEN-1:0]    signed_imm_24_in;
    logic [3:0]              dest_in;
    logic [3:0]              src1_in;
    logic [3:0]              src2_in;
    logic [3:0]              status_in;

    // EXE-side registered fields
    logic [REG_LEN-1:0]      pc;
    logic                    wb_en;
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic                    b;
    logic                    s;
    logic                    imm;
    logic [CMD_LEN-1:0]      exe_cmd;
    logic [REG_LEN-1:0]      val_rn;
    logic [REG_LEN-1:0]      val_rm;
    logic [SHIFT_OP_LEN-1:0] shift_operand;
    logic [IMM24_LEN-1:0]    signed_imm_24;
    logic [3:0]              dest;
    logic [3:0]              src1;
    logic [3:0]              src2;
    logic [3:0]              status;
    logic                    is_mem_related;
    logic                    valid;

    modport master (
        output flush, freeze,
        output pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
        output exe_cmd_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
        output dest_in, src1_in, src2_in, status_in,
        input  pc, wb_en, mem_r_en, mem_w_en, b, s, imm,
        input  exe_cmd, val_rn, val_rm, shift_operand, signed_imm_24,
        input  dest, src1, src2, status, is_mem_related, valid
    );

    modport slave (
        input  flush, freeze,
        input  pc_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
        input  exe_cmd_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
        input  dest_in, src1_in, src2_in, status_in,
        output pc, wb_en, mem_r_en, mem_w_en, b, s, imm,
        output exe_cmd, val_rn, val_rm, shift_operand, signed_imm_24,
        output dest, src1, src2, status, is_mem_related, valid
    );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register: captures decoded controls, operands and shifter fields; flush loads a bubble.
// Latency: 1 cycle, fully registered outputs (no input-to-output combinational path).
// Backpressure: freeze holds every field; flush overrides freeze so a taken branch is never blocked.
// Ports: clk, rst (async active-high); bus (slave modport) carries flush/freeze, *_in fields and the
//        registered outputs including is_mem_related and valid.
module id_exe_stage_reg #(
    parameter int REG_LEN      = 32,
    parameter int SHIFT_OP_LEN = 12,
    parameter int IMM24_LEN    = 24,
    parameter int CMD_LEN      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    id_exe_stage_reg_if.slave       bus
);

    typedef struct packed {
        logic [REG_LEN-1:0]      pc;
        logic                    wb_en;
        logic                    mem_r_en;
        logic                    mem_w_en;
        logic                    b;
        logic                    s;
        logic                    imm;
        logic [CMD_LEN-1:0]      exe_cmd;
        logic [REG_LEN-1:0]      val_rn;
        logic [REG_LEN-1:0]      val_rm;
        logic [SHIFT_OP_LEN-1:0] shift_operand;
        logic [IMM24_LEN-1:0]    signed_imm_24;
        logic [3:0]              dest;
        logic [3:0]              src1;
        logic [3:0]              src2;
        logic [3:0]              status;
        logic                    is_mem_related;
        logic                    valid;
    } stage_t;

    stage_t next_dat;
    stage_t stage_q;

    // Incoming instruction image; fields are stored verbatim, sign extension is EXE's job.
    always_comb begin
        next_dat                = '0;
        next_dat.pc             = bus.pc_in;
        next_dat.wb_en          = bus.wb_en_in;
        next_dat.mem_r_en       = bus.mem_r_en_in;
        next_dat.mem_w_en       = bus.mem_w_en_in;
        next_dat.b              = bus.b_in;
        next_dat.s              = bus.s_in;
        next_dat.imm            = bus.imm_in;
        next_dat.exe_cmd        = bus.exe_cmd_in;
        next_dat.val_rn         = bus.val_rn_in;
        next_dat.val_rm         = bus.val_rm_in;
        next_dat.shift_operand  = bus.shift_operand_in;
        next_dat.signed_imm_24  = bus.signed_imm_24_in;
        next_dat.dest           = bus.dest_in;
        next_dat.src1           = bus.src1_in;
        next_dat.src2           = bus.src2_in;
        next_dat.status         = bus.status_in;
        // Pre-decoded so EXE/MEM need no look at the individual enables.
        next_dat.is_mem_related = bus.mem_r_en_in | bus.mem_w_en_in;
        next_dat.valid          = 1'b1;
    end

    // A bubble is the all-zero image: no side-effect bits, deterministic data fields.
    // Flush is tested before freeze so a stall can never hold back a branch redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else if (bus.flush) begin
            stage_q <= '0;
        end else if (!bus.freeze) begin
            stage_q <= next_dat;
        end
    end

    assign bus.pc             = stage_q.pc;
    assign bus.wb_en          = stage_q.wb_en;
    assign bus.mem_r_en       = stage_q.mem_r_en;
    assign bus.mem_w_en       = stage_q.mem_w_en;
    assign bus.b              = stage_q.b;
    assign bus.s              = stage_q.s;
    assign bus.imm            = stage_q.imm;
    assign bus.exe_cmd        = stage_q.exe_cmd;
    assign bus.val_rn         = stage_q.val_rn;
    assign bus.val_rm         = stage_q.val_rm;
    assign bus.shift_operand  = stage_q.shift_operand;
    assign bus.signed_imm_24  = stage_q.signed_imm_24;
    assign bus.dest           = stage_q.dest;
    assign bus.src1           = stage_q.src1;
    assign bus.src2           = stage_q.src2;
    assign bus.status         = stage_q.status;
    assign bus.is_mem_related = stage_q.is_mem_related;
    assign bus.valid          = stage_q.valid;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
module tb_id_exe_stage_reg;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    id_exe_stage_reg_if bus ();

    id_exe_stage_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus variables ----------------
    logic [31:0] i_pc, i_rn, i_rm;
    logic        i_wb, i_mr, i_mw, i_b, i_s, i_imm, i_flush, i_freeze;
    logic [3:0]  i_cmd, i_dest, i_src1, i_src2, i_status;
    logic [11:0] i_sh;
    logic [23:0] i_si;

    // ---------------- reference model: one record of what EXE should see ----------------
    typedef struct {
        logic [31:0] pc, rn, rm;
        logic        wb, mr, mw, b, s, imm, ismem, valid;
        logic [3:0]  cmd, dest, src1, src2, status;
        logic [11:0] sh;
        logic [23:0] si;
    } rec_t;

    rec_t exp_r;
    rec_t bubble_r;

    function automatic rec_t inputs_as_rec();
        rec_t r;
        r.pc = i_pc; r.rn = i_rn; r.rm = i_rm;
        r.wb = i_wb; r.mr = i_mr; r.mw = i_mw; r.b = i_b; r.s = i_s; r.imm = i_imm;
        r.cmd = i_cmd; r.dest = i_dest; r.src1 = i_src1; r.src2 = i_src2; r.status = i_status;
        r.sh = i_sh; r.si = i_si;
        r.ismem = i_mr | i_mw;      // instruction touches memory
        r.valid = 1'b1;             // a loaded slot holds a real instruction
        return r;
    endfunction

    task automatic drive();
        bus.flush = i_flush; bus.freeze = i_freeze;
        bus.pc_in = i_pc; bus.wb_en_in = i_wb; bus.mem_r_en_in = i_mr; bus.mem_w_en_in = i_mw;
        bus.b_in = i_b; bus.s_in = i_s; bus.imm_in = i_imm; bus.exe_cmd_in = i_cmd;
        bus.val_rn_in = i_rn; bus.val_rm_in = i_rm; bus.shift_operand_in = i_sh;
        bus.signed_imm_24_in = i_si; bus.dest_in = i_dest; bus.src1_in = i_src1;
        bus.src2_in = i_src2; bus.status_in = i_status;
    endtask

    task automatic set_all(input logic [31:0] v);
        i_pc = v; i_rn = v; i_rm = v; i_wb = v[0]; i_mr = v[1]; i_mw = v[2]; i_b = v[3];
        i_s = v[4]; i_imm = v[5]; i_cmd = v[3:0]; i_dest = v[7:4]; i_src1 = v[11:8];
        i_src2 = v[15:12]; i_status = v[19:16]; i_sh = v[11:0]; i_si = v[23:0];
        drive();
    endtask

    task automatic rand_inputs();
        i_pc = $urandom; i_rn = $urandom; i_rm = $urandom;
        {i_wb, i_mr, i_mw, i_b, i_s, i_imm} = 6'($urandom);
        i_cmd = 4'($urandom); i_dest = 4'($urandom); i_src1 = 4'($urandom);
        i_src2 = 4'($urandom); i_status = 4'($urandom);
        i_sh = 12'($urandom); i_si = 24'($urandom);
        drive();
    endtask

    // One rising edge: update the expectation from the rules, then sample 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        if (rst || i_flush) exp_r = bubble_r;
        else if (!i_freeze) exp_r = inputs_as_rec();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},     bus.pc,                    exp_r.pc);
        chk({tag, ".wb"},     32'(bus.wb_en),            32'(exp_r.wb));
        chk({tag, ".mr"},     32'(bus.mem_r_en),         32'(exp_r.mr));
        chk({tag, ".mw"},     32'(bus.mem_w_en),         32'(exp_r.mw));
        chk({tag, ".b"},      32'(bus.b),                32'(exp_r.b));
        chk({tag, ".s"},      32'(bus.s),                32'(exp_r.s));
        chk({tag, ".imm"},    32'(bus.imm),              32'(exp_r.imm));
        chk({tag, ".cmd"},    32'(bus.exe_cmd),          32'(exp_r.cmd));
        chk({tag, ".rn"},     bus.val_rn,                exp_r.rn);
        chk({tag, ".rm"},     bus.val_rm,                exp_r.rm);
        chk({tag, ".sh"},     32'(bus.shift_operand),    32'(exp_r.sh));
        chk({tag, ".si"},     32'(bus.signed_imm_24),    32'(exp_r.si));
        chk({tag, ".dest"},   32'(bus.dest),             32'(exp_r.dest));
        chk({tag, ".src1"},   32'(bus.src1),             32'(exp_r.src1));
        chk({tag, ".src2"},   32'(bus.src2),             32'(exp_r.src2));
        chk({tag, ".status"}, 32'(bus.status),           32'(exp_r.status));
        chk({tag, ".ismem"},  32'(bus.is_mem_related),   32'(exp_r.ismem));
        chk({tag, ".valid"},  32'(bus.valid),            32'(exp_r.valid));
    endtask

    initial begin
        logic [31:0] pc_q[$];
        logic [31:0] want_pc;
        tests = 0;
        fails = 0;
        bubble_r = '{pc: 0, rn: 0, rm: 0, wb: 0, mr: 0, mw: 0, b: 0, s: 0, imm: 0, ismem: 0,
                     valid: 0, cmd: 0, dest: 0, src1: 0, src2: 0, status: 0, sh: 0, si: 0};
        exp_r = bubble_r;

        // Reset with every input at 1s for two edges.
        rst = 1'b1;
        i_flush = 1'b1; i_freeze = 1'b1;
        set_all(32'hFFFF_FFFF);
        cycle();
        cycle();
        check_all("reset");

        // Directed load.
        rst = 1'b0; i_flush = 1'b0; i_freeze = 1'b0;
        set_all(32'h0);
        i_pc = 32'h0000_0010; i_rm = 32'hF000_000F; i_sh = 12'h3E2; i_imm = 1'b0;
        i_mr = 1'b1; i_dest = 4'd5;
        drive();
        cycle();
        check_all("load");
        chk("load_ismem_const", 32'(bus.is_mem_related), 32'd1);
        chk("load_valid_const", 32'(bus.valid), 32'd1);
        chk("load_rm_const", bus.val_rm, 32'hF000_000F);

        // Inputs change mid-cycle: outputs must not follow without an edge.
        #2;
        set_all(32'h1234_5678);
        #1;
        check_all("no_comb");

        // Freeze for 3 edges with new inputs present, then release.
        i_freeze = 1'b1;
        set_all(32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_all("freeze");
            chk("freeze_pc_const", bus.pc, 32'h0000_0010);
        end
        i_freeze = 1'b0;
        drive();
        cycle();
        check_all("unfreeze");
        chk("unfreeze_pc_const", bus.pc, 32'hDEAD_BEEF);

        // Load a side-effecting instruction, then flush it away.
        set_all(32'h0);
        i_wb = 1'b1; i_mw = 1'b1; i_b = 1'b1; i_pc = 32'h0000_0040; i_rn = 32'hA5A5_A5A5;
        drive();
        cycle();
        check_all("pre_flush");
        i_flush = 1'b1;
        rand_inputs();
        cycle();
        check_all("flush");
        chk("flush_valid_const", 32'(bus.valid), 32'd0);

        // Flush and freeze together: bubble wins over hold.
        i_flush = 1'b0; i_freeze = 1'b0;
        rand_inputs();
        cycle();
        check_all("pre_ff");
        i_flush = 1'b1; i_freeze = 1'b1;
        rand_inputs();
        cycle();
        check_all("flush_freeze");

        // Back-to-back loads, pc 0,4,8,12 must each appear exactly one edge later.
        i_flush = 1'b0; i_freeze = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_inputs();
            i_pc = 32'(k * 4);
            drive();
            pc_q.push_back(i_pc);
            cycle();
            want_pc = pc_q.pop_front();
            chk("b2b_pc", bus.pc, want_pc);
            check_all("b2b");
        end

        // Asynchronous reset between edges, in the middle of a freeze.
        i_freeze = 1'b1;
        rand_inputs();
        cycle();
        #2;
        rst = 1'b1;
        exp_r = bubble_r;
        #1;
        check_all("async_rst");
        cycle();
        check_all("rst_held");
        #2;
        rst = 1'b0;
        i_freeze = 1'b0;
        rand_inputs();
        cycle();
        check_all("rst_release");

        // Randomized traffic with occasional flush/freeze.
        for (int n = 0; n < 300; n++) begin
            rand_inputs();
            i_flush  = ($urandom_range(0, 7) == 0);
            i_freeze = ($urandom_range(0, 3) == 0);
            drive();
            cycle();
            check_all("rand");
            if (!bus.valid) begin
                chk("bubble_side_fx", 32'({bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.b, bus.s}), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- Pipeline register between the Instruction Decode stage and the Execute stage of the 5-stage ARM core.
- Captures the decoded control bits, the register operands val_rn and val_rm, and the shifter fields that the EXE stage's second-operand generator and ALU consume.
- Supports freeze (hazard or memory stall hold) and flush (bubble injection on taken branch).
- Registers the is_mem_related and valid qualifiers so EXE needs no decode logic.

Parameters:
- REG_LEN, 32, datapath and register-file word width.
- SHIFT_OP_LEN, 12, shifter-operand field width.
- IMM24_LEN, 24, branch signed-immediate width.
- CMD_LEN, 4, ALU execute-command width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  taken branch in EXE; load a bubble.
- freeze  in  1  hold all contents (hazard or memory stall).
- pc_in  in  REG_LEN  PC+4 of the ID instruction.
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in  in  1 each  decoded control bits.
- exe_cmd_in  in  CMD_LEN  ALU command.
- val_rn_in, val_rm_in  in  REG_LEN  register-file read data.
- shift_operand_in  in  SHIFT_OP_LEN  instruction bits [11:0].
- signed_imm_24_in  in  IMM24_LEN  branch offset.
- dest_in, src1_in, src2_in  in  4 each  destination and source register numbers (src1/src2 used for forwarding).
- status_in  in  4  NZCV flags visible in ID.
- Outputs: pc, wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd, val_rn, val_rm, shift_operand, signed_imm_24, dest, src1, src2, status, registered copies of the inputs above with the same widths.
- is_mem_related  out  1  registered (mem_r_en_in | mem_w_en_in).
- valid  out  1  stage holds a real instruction.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clk): every output is 0, including valid=0 and is_mem_related=0. Release takes effect at the next rising edge after rst falls.
- Each rising edge with rst=0, priority is flush > freeze > load.
- Flush: the control bits wb_en, mem_r_en, mem_w_en, b, s, is_mem_related and valid become 0. exe_cmd, imm, dest, src1 and src2 also become 0. Data fields pc, val_rn, val_rm, shift_operand, signed_imm_24 and status also clear to 0, so bubble contents are deterministic.
- Freeze (flush=0): all outputs keep their values, with no partial updates. freeze held N cycles means the outputs are held for N edges.
- Load (flush=0, freeze=0): every output takes its _in value. valid becomes 1 and is_mem_related becomes mem_r_en_in | mem_w_en_in.
- Flush and freeze together: flush wins and a bubble is inserted. A branch must never be blocked by a stall.
- Latency: exactly 1 cycle from ID input to EXE-visible output. There is no combinational path from any input to any output.
- A bubble must never assert wb_en, mem_r_en, mem_w_en, b or s. This guarantees no architectural side effects.
- imm and is_mem_related are mutually independent. Precedence between them (mem first) is resolved downstream; this stage passes both unchanged.
- Width rule: all fields are stored verbatim, with no sign extension or truncation. signed_imm_24 extension happens in EXE.
- Reset asserted mid-freeze or mid-flush: the reset values win immediately. Contents are not restored on release.

Test Plan:
- Reset: rst=1 for 2 cycles with all inputs at 1s → all outputs 0 and valid=0. Assert rst between clock edges → outputs clear without waiting for an edge.
- Load: pc_in=32'h0000_0010, val_rm_in=32'hF000_000F, shift_operand_in=12'h3E2, imm_in=0, mem_r_en_in=1, dest_in=4'd5 → after one edge the outputs match, is_mem_related=1 and valid=1.
- Freeze: load a value as above, then hold freeze=1 for 3 cycles while changing all inputs to 32'hDEAD_BEEF and similar values → outputs unchanged for 3 edges; the new values appear on the edge after freeze falls.
- Flush: load wb_en=1, mem_w_en=1, b=1, then assert flush=1 → the next edge gives wb_en=0, mem_w_en=0, b=0, s=0, valid=0 and all data fields 0.
- Flush+freeze together: flush=1 and freeze=1 → a bubble is loaded (valid=0), not the held contents.
- Back-to-back loads: 4 consecutive instructions with distinct pc_in values 0, 4, 8, 12 → the pc outputs follow one cycle later, with no dropped or duplicated values.
